// File: rtl/sensor_router_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sensor_router_pkg
// Desc     : Shared state encoding, ASCII constants and parameter checks for
//            the UART-command-to-sensor router.
// Revision : 1.0  initial release
// ============================================================================
package sensor_router_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        CONV  = 3'd3,
        SEND  = 3'd4,
        ERR   = 3'd5
    } router_state_t;

    localparam logic [7:0] CMD_BASE   = 8'h41;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_ERR  = 8'h45;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // True when DIGITS decimal digits can represent every DW-bit unsigned value.
    function automatic bit digits_ok(input int dw, input int digits);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            if (p > (64'd1 << 59)) return 1'b1;
            p = p * 64'd10;
        end
        if (dw >= 63) return 1'b0;
        return (p >= (64'd1 << dw));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2ascii_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2ascii_seq
// Desc     : Sequential double-dabble; DW shift steps then a one-cycle done,
//            producing DIGITS ASCII digits (digit 0 = least significant).
// Revision : 1.0  initial release
// ============================================================================
module bin2ascii_seq
    import sensor_router_pkg::*;
#(
    parameter int DW     = 16,
    parameter int DIGITS = 5
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DW-1:0]         bin,
    output logic                  done,
    output logic [8*DIGITS-1:0]   ascii
);

    localparam int CNW = $clog2(DW + 1);
    localparam int BW  = 4 * DIGITS;

    generate
        if (!digits_ok(DW, DIGITS)) begin : g_bad_digits
            $error("bin2ascii_seq: 10**DIGITS must exceed 2**DW-1");
        end
    endgenerate

    logic [BW-1:0]    r_bcd;
    logic [DW-1:0]    r_bin;
    logic [CNW-1:0]   r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [BW-1:0]    w_src_bcd;
    logic [DW-1:0]    w_src_bin;
    logic [BW-1:0]    w_adj;
    logic [BW+DW-1:0] w_cat;

    // The first shift happens in the start cycle, so DW steps end one cycle
    // before done and the whole conversion spans DW+1 cycles.
    always_comb begin
        w_src_bcd = start ? '0 : r_bcd;
        w_src_bin = start ? bin : r_bin;
        w_adj     = w_src_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_src_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = w_src_bcd[4*d +: 4] + 4'd3;
            end
        end
        w_cat = {w_adj, w_src_bin} << 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcd  <= '0;
            r_bin  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                {r_bcd, r_bin} <= w_cat;
                r_cnt          <= CNW'(1);
                if (DW == 1) begin
                    r_done <= 1'b1;
                end else begin
                    r_busy <= 1'b1;
                end
            end else if (r_busy) begin
                {r_bcd, r_bin} <= w_cat;
                r_cnt          <= r_cnt + 1'b1;
                if (r_cnt == CNW'(DW - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            assign ascii[8*d +: 8] = ASCII_ZERO + {4'h0, r_bcd[4*d +: 4]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sensor_cmd_router.sv
`default_nettype none
// ============================================================================
// Module   : sensor_cmd_router
// Desc     : Routes a UART command byte to one of NCH sensors and returns the
//            result as fixed-width decimal ASCII plus CR, or 'E',CR on timeout.
// Revision : 1.0  initial release
// ============================================================================
module sensor_cmd_router
    import sensor_router_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DW          = 16,
    parameter int DIGITS      = 5,
    parameter int TIMEOUT_CYC = 1_000_000
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [NCH-1:0]      ch_start,
    input  logic [NCH-1:0]      ch_valid,
    input  logic [NCH*DW-1:0]   ch_data,
    output logic                busy,
    output logic                cmd_drop
);

    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int IW = $clog2(DIGITS + 2);

    localparam logic [CW-1:0] c_TMO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] c_SEND_LAST = IW'(DIGITS);
    localparam logic [IW-1:0] c_ERR_LAST  = IW'(1);

    generate
        if (NCH < 1 || NCH > 8) begin : g_bad_nch
            $error("sensor_cmd_router: NCH must be in 1..8");
        end
    endgenerate

    router_state_t          r_state;
    router_state_t          w_next;
    logic [SW-1:0]          r_sel;
    logic [DW-1:0]          r_cap;
    logic [CW-1:0]          r_tmo;
    logic [IW-1:0]          r_idx;
    logic                   r_conv_start;
    logic                   r_cmd_drop;

    logic [7:0]             w_off;
    logic                   w_cmd_ok;
    logic                   w_sel_valid;
    logic [DW-1:0]          w_sel_data;
    logic [NCH-1:0]         w_start_vec;
    logic                   w_xfer;
    logic                   w_conv_done;
    logic [8*DIGITS-1:0]    w_ascii;
    logic [7:0]             w_byte;

    assign w_off    = rx_data - CMD_BASE;
    assign w_cmd_ok = (rx_data >= CMD_BASE) && (w_off < 8'(NCH));
    assign w_xfer   = ((r_state == SEND) || (r_state == ERR)) && tx_ready;

    // Only the latched channel is looked at; other strobes are ignored.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_start_vec = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_sel == SW'(i)) begin
                w_sel_valid    = ch_valid[i];
                w_sel_data     = ch_data[i*DW +: DW];
                w_start_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_byte = ASCII_CR;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_idx == IW'(DIGITS - 1 - d)) begin
                w_byte = w_ascii[8*d +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        ch_start = '0;
        busy     = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (rx_valid && w_cmd_ok) w_next = START;
            end
            START: begin
                ch_start = w_start_vec;
                w_next   = WAIT;
            end
            WAIT: begin
                // Data arriving on the final timeout cycle takes priority.
                if (w_sel_valid)              w_next = CONV;
                else if (r_tmo == c_TMO_LAST) w_next = ERR;
            end
            CONV: begin
                if (w_conv_done) w_next = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = w_byte;
                if (w_xfer && (r_idx == c_SEND_LAST)) w_next = IDLE;
            end
            ERR: begin
                tx_valid = 1'b1;
                tx_data  = (r_idx == '0) ? ASCII_ERR : ASCII_CR;
                if (w_xfer && (r_idx == c_ERR_LAST)) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel        <= '0;
            r_cap        <= '0;
            r_tmo        <= '0;
            r_idx        <= '0;
            r_conv_start <= 1'b0;
            r_cmd_drop   <= 1'b0;
        end else begin
            r_cmd_drop   <= rx_valid && ((r_state != IDLE) || !w_cmd_ok);
            r_conv_start <= (r_state == WAIT) && w_sel_valid;

            if ((r_state == IDLE) && rx_valid && w_cmd_ok) begin
                r_sel <= w_off[SW-1:0];
            end

            if ((r_state == WAIT) && w_sel_valid) begin
                r_cap <= w_sel_data;
            end

            if (r_state == START) begin
                r_tmo <= '0;
            end else if ((r_state == WAIT) && (r_tmo != c_TMO_LAST)) begin
                r_tmo <= r_tmo + 1'b1;
            end

            // Byte index only moves on a completed transfer.
            if ((r_state == SEND) || (r_state == ERR)) begin
                if (w_xfer) r_idx <= r_idx + 1'b1;
            end else begin
                r_idx <= '0;
            end
        end
    end

    assign cmd_drop = r_cmd_drop;

    bin2ascii_seq #(
        .DW     (DW),
        .DIGITS (DIGITS)
    ) u_bin2ascii (
        .clk    (clk),
        .rst    (rst),
        .start  (r_conv_start),
        .bin    (r_cap),
        .done   (w_conv_done),
        .ascii  (w_ascii)
    );

endmodule
`default_nettype wire

// File: tb/tb_sensor_cmd_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_cmd_router
// Desc     : Scoreboard bench for sensor_cmd_router (NCH=4, DW=16, 5 digits).
// Revision : 1.0  initial release
// ============================================================================
module tb_sensor_cmd_router;

    localparam int NCH    = 4;
    localparam int DW     = 16;
    localparam int DIGITS = 5;
    localparam int TMO    = 100;

    logic               clk;
    logic               rst;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [NCH-1:0]     ch_start;
    logic [NCH-1:0]     ch_valid;
    logic [NCH*DW-1:0]  ch_data;
    logic               busy;
    logic               cmd_drop;

    sensor_cmd_router #(
        .NCH         (NCH),
        .DW          (DW),
        .DIGITS      (DIGITS),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .ch_start (ch_start),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .busy     (busy),
        .cmd_drop (cmd_drop)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          n_start = 0;
    int          n_drop  = 0;
    bit          stall   = 1'b0;
    logic [7:0]  exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // tx_ready driver: always ready, or ready one cycle in three while stalling.
    initial begin
        int ph;
        ph = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = stall ? (ph % 3 == 0) : 1'b1;
            ph++;
        end
    end

    // Output monitor: scoreboard pop on transfer, hold check while stalled.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (ch_start != '0) n_start++;
            if (cmd_drop) n_drop++;
            if (prev_stall) begin
                check("tx_hold_valid", 32'(tx_valid), 32'(1));
                check("tx_hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                check("tx_expected_pending", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push_reply(input logic [15:0] val);
        int v;
        int p;
        v = int'(val);
        for (int d = DIGITS - 1; d >= 0; d--) begin
            p = 1;
            for (int j = 0; j < d; j++) p = p * 10;
            exp_q.push_back(8'(8'h30 + (v / p) % 10));
        end
        exp_q.push_back(8'h0D);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Returns at the negedge of the first WAIT cycle; s = cycle count in START.
    task automatic wait_start(input int ch, output int s);
        bit found;
        found = 1'b0;
        s = cyc;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ch_start != '0) begin
                found = 1'b1;
                s = cyc;
            end
        end
        check("ch_start_seen", 32'(found), 32'(1));
        check("ch_start_onehot", 32'(ch_start), 32'(1 << ch));
        @(negedge clk);
        check("ch_start_one_cycle", 32'(ch_start), 32'(0));
    endtask

    task automatic wait_tx();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
        check("tx_valid_seen", 32'(seen), 32'(1));
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        check("reply_drained", 32'(ok), 32'(1));
    endtask

    // Result strobe lands in WAIT cycle number wc (1 = first WAIT cycle);
    // a decoy strobe on a neighbour channel precedes it when there is room.
    task automatic issue_req(input int ch, input logic [15:0] val, input int wc);
        int s;
        int oc;
        oc = (ch + 1) % NCH;
        push_reply(val);
        ch_data[ch*DW +: DW] = val;
        ch_data[oc*DW +: DW] = 16'd9999;
        send_cmd(8'(8'h41 + ch));
        wait_start(ch, s);
        if (wc > 2) begin
            #1 ch_valid[oc] = 1'b1;
            @(posedge clk);
            #1 ch_valid[oc] = 1'b0;
            repeat (wc - 2) @(posedge clk);
        end else begin
            repeat (wc - 1) @(posedge clk);
        end
        #1 ch_valid[ch] = 1'b1;
        @(posedge clk);
        #1 ch_valid[ch] = 1'b0;
    endtask

    task automatic do_req(input int ch, input logic [15:0] val, input int wc);
        issue_req(ch, val, wc);
        drain();
    endtask

    initial begin
        int s;
        int t_err;
        int s0;
        int d0;
        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        ch_valid = '0;
        ch_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_ch_start", 32'(ch_start), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cmd_drop", 32'(cmd_drop), 32'(0));
        rst = 1'b1;

        // Basic request, full-scale and zero values
        do_req(1, 16'd1234, 50);
        do_req(0, 16'hFFFF, 10);
        do_req(0, 16'd0, 3);

        // Timeout: WAIT lasts TMO cycles, so 'E' appears TMO+1 cycles after START
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h0D);
        send_cmd(8'h41);
        wait_start(0, s);
        t_err = cyc;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(negedge clk);
                if (tx_valid) begin
                    seen  = 1'b1;
                    t_err = cyc;
                end
            end
            check("err_seen", 32'(seen), 32'(1));
        end
        check("err_latency", 32'(t_err - s), 32'(TMO + 1));
        drain();

        // Result on the last WAIT cycle beats the timeout
        do_req(2, 16'd4321, TMO);

        // Backpressure: ready one cycle in three
        stall = 1'b1;
        do_req(3, 16'd40961, 20);

        // Command during SEND is dropped, reply continues unchanged
        issue_req(1, 16'd808, 5);
        wait_tx();
        s0 = n_start;
        d0 = n_drop;
        send_cmd(8'h43);
        repeat (3) @(negedge clk);
        check("drop_in_send", 32'(n_drop - d0), 32'(1));
        check("no_start_in_send", 32'(n_start - s0), 32'(0));
        check("busy_in_send", 32'(busy), 32'(1));
        drain();
        stall = 1'b0;

        // Unknown command in IDLE
        s0 = n_start;
        d0 = n_drop;
        send_cmd(8'h5A);
        repeat (4) @(negedge clk);
        check("drop_bad_cmd", 32'(n_drop - d0), 32'(1));
        check("no_start_bad_cmd", 32'(n_start - s0), 32'(0));
        check("idle_bad_cmd", 32'(busy), 32'(0));

        // Asynchronous reset in the middle of a reply
        stall = 1'b1;
        issue_req(0, 16'd777, 4);
        wait_tx();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_tx_valid", 32'(tx_valid), 32'(0));
        check("arst_tx_data", 32'(tx_data), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_ch_start", 32'(ch_start), 32'(0));
        check("arst_cmd_drop", 32'(cmd_drop), 32'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        stall = 1'b0;
        do_req(0, 16'd31415, 7);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
